// File: rtl/ami_seq_pkg.sv
// ---------------------------------------------------------------------------
// ami_seq_pkg
// Shared types and helpers for the AMI command sequencer.
//   seq_state_t : sequencer FSM states
//   TIMER_W     : width of the per-attempt ack timer
//   RETRY_W     : width of the retry counter
//   ch_onehot() : channel number -> one-hot request vector
// ---------------------------------------------------------------------------
package ami_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } seq_state_t;

  localparam int TIMER_W  = 16;
  localparam int RETRY_W  = 8;
  localparam int ONEHOT_W = 32;

  // Wide one-hot; callers cast it down to their channel count.
  function automatic logic [ONEHOT_W-1:0] ch_onehot(input logic [7:0] ch);
    logic [ONEHOT_W-1:0] oh;
    oh = {ONEHOT_W{1'b0}};
    if (ch < 8'd32) begin
      oh[ch[4:0]] = 1'b1;
    end else begin
      oh = {ONEHOT_W{1'b0}};
    end
    return oh;
  endfunction

endpackage

// File: rtl/ami_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// ami_cmd_sequencer_if
// Bundles the JTAG command port, the AMI request/ack bus and the result port.
//   slave  : the sequencer (accepts commands, drives AMI requests/results)
//   master : the environment (offers commands, answers AMI requests)
// ---------------------------------------------------------------------------
interface ami_cmd_sequencer_if #(
  parameter int DATA_W = 256,
  parameter int N_CH   = 3,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  import ami_seq_pkg::*;

  logic [DATA_W-1:0] jtag_in;
  logic [CH_W-1:0]   jtag_ch;
  logic              jtag_valid;
  logic              jtag_ready;
  logic [DATA_W-1:0] fsm_ami;
  logic [N_CH-1:0]   ami_req;
  logic [N_CH-1:0]   ami_ack;
  logic [DATA_W-1:0] ami_out;
  logic [DATA_W-1:0] rsp_data;
  logic [CH_W-1:0]   rsp_ch;
  logic              rsp_valid;
  logic              rsp_err;
  logic              irq;

  modport slave (
    input  jtag_in, jtag_ch, jtag_valid, ami_ack, ami_out,
    output jtag_ready, fsm_ami, ami_req, rsp_data, rsp_ch, rsp_valid, rsp_err, irq
  );

  modport master (
    output jtag_in, jtag_ch, jtag_valid, ami_ack, ami_out,
    input  jtag_ready, fsm_ami, ami_req, rsp_data, rsp_ch, rsp_valid, rsp_err, irq
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Saturating count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1'b1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ami_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ami_cmd_sequencer
// Takes command words from the JTAG debug port, issues each one to a single
// AMI channel with a request/ack handshake, captures the response and
// retries on timeout before reporting an error.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : command / AMI / result signals (slave side)
//   busy      : sequencer is not idle
//   ok_count  : saturating count of successful commands
//   err_count : saturating count of errored commands
// ---------------------------------------------------------------------------
module ami_cmd_sequencer
  import ami_seq_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int N_CH      = 3,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ami_cmd_sequencer_if.slave   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     ok_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  seq_state_t         state_r, state_nx_s;
  logic [DATA_W-1:0]  word_r, word_nx_s;
  logic [CH_W-1:0]    ch_r, ch_nx_s;
  logic [TIMER_W-1:0] timer_r, timer_nx_s;
  logic [RETRY_W-1:0] retry_r, retry_nx_s;
  logic               capture_s;
  logic               ack_hit_s;
  logic               ch_ok_s;
  logic [N_CH-1:0]    cur_oh_s;
  logic [N_CH-1:0]    nx_oh_s;

  logic [DATA_W-1:0]  fsm_ami_r;
  logic [N_CH-1:0]    ami_req_r;
  logic [DATA_W-1:0]  rsp_data_r;
  logic [CH_W-1:0]    rsp_ch_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic               irq_r;
  logic               busy_r;

  // Only the ack of the channel being served counts; others are stray.
  assign cur_oh_s  = N_CH'(ch_onehot(8'(ch_r)));
  assign nx_oh_s   = N_CH'(ch_onehot(8'(ch_nx_s)));
  assign ack_hit_s = |(bus.ami_ack & cur_oh_s);
  assign ch_ok_s   = (32'(bus.jtag_ch) < 32'(N_CH));

  // Next-state and next-context logic.
  always_comb begin
    state_nx_s = state_r;
    word_nx_s  = word_r;
    ch_nx_s    = ch_r;
    timer_nx_s = timer_r;
    retry_nx_s = retry_r;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.jtag_valid) begin
          word_nx_s  = bus.jtag_in;
          ch_nx_s    = bus.jtag_ch;
          timer_nx_s = {TIMER_W{1'b0}};
          retry_nx_s = {RETRY_W{1'b0}};
          if (ch_ok_s) begin
            state_nx_s = WAIT;
          end else begin
            state_nx_s = ERR;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        // An ack in the expiry cycle still counts as success.
        if (ack_hit_s) begin
          capture_s  = 1'b1;
          state_nx_s = DONE;
        end else if (timer_r == TMO_LAST) begin
          if (retry_r < RETRY_MAX) begin
            retry_nx_s = retry_r + RETRY_W'(1'b1);
            state_nx_s = GAP;
          end else begin
            state_nx_s = ERR;
          end
        end else begin
          timer_nx_s = timer_r + TIMER_W'(1'b1);
        end
      end
      GAP: begin
        timer_nx_s = {TIMER_W{1'b0}};
        state_nx_s = WAIT;
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      ERR: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, context and registered outputs; outputs follow the next state so
  // they line up with the cycle the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      word_r      <= {DATA_W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      timer_r     <= {TIMER_W{1'b0}};
      retry_r     <= {RETRY_W{1'b0}};
      fsm_ami_r   <= {DATA_W{1'b0}};
      ami_req_r   <= {N_CH{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_ch_r    <= {CH_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      irq_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      word_r      <= word_nx_s;
      ch_r        <= ch_nx_s;
      timer_r     <= timer_nx_s;
      retry_r     <= retry_nx_s;
      ami_req_r   <= (state_nx_s == WAIT) ? nx_oh_s : {N_CH{1'b0}};
      fsm_ami_r   <= (state_nx_s == WAIT) ? word_nx_s : {DATA_W{1'b0}};
      rsp_valid_r <= (state_nx_s == DONE) || (state_nx_s == ERR);
      irq_r       <= (state_nx_s == DONE) || (state_nx_s == ERR);
      busy_r      <= (state_nx_s != IDLE);
      if (capture_s) begin
        rsp_data_r <= bus.ami_out;
        rsp_ch_r   <= ch_r;
        rsp_err_r  <= 1'b0;
      end else if (state_nx_s == ERR) begin
        rsp_data_r <= {DATA_W{1'b0}};
        rsp_ch_r   <= ch_nx_s;
        rsp_err_r  <= 1'b1;
      end
    end
  end

  // Result counters tick on the cycle the result is presented.
  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_r == DONE),
    .count (ok_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_r == ERR),
    .count (err_count)
  );

  // Ready is gated by reset so commands offered during reset are never seen
  // as accepted.
  assign bus.jtag_ready = rst_n & (state_r == IDLE);
  assign bus.fsm_ami    = fsm_ami_r;
  assign bus.ami_req    = ami_req_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_ch     = rsp_ch_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.irq        = irq_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_ami_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ami_cmd_sequencer
// Self-checking bench for ami_cmd_sequencer. Expected behaviour comes from a
// cycle-position model: relative to command acceptance, attempt k occupies
// WAIT cycles k*(TIMEOUT+1)+1 .. k*(TIMEOUT+1)+TIMEOUT with a single gap
// cycle between attempts; a one-cycle ack on a WAIT cycle d succeeds with the
// result in cycle d+1, otherwise the error lands after the last attempt.
// ---------------------------------------------------------------------------
module tb_ami_cmd_sequencer;

  localparam int DATA_W    = 256;
  localparam int N_CH      = 3;
  localparam int CH_W      = 2;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 2;
  localparam int LAST      = (MAX_RETRY + 1) * TIMEOUT + MAX_RETRY;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] err_count;

  int vectors     = 0;
  int miscompares = 0;
  int m_ok        = 0;
  int m_err       = 0;

  ami_cmd_sequencer_if #(.DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W)) bus ();

  ami_cmd_sequencer #(
    .DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .ok_count  (ok_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit is_wait_cycle(int r);
    return (r >= 1) && (r <= LAST) && ((r % (TIMEOUT + 1)) != 0);
  endfunction

  // Offer one command at the current negedge (sequencer idle) and follow it
  // until the cycle after its result. Ack pulse on ch in relative cycle d.
  task automatic run_cmd(input logic [DATA_W-1:0] word, input int ch, input int d,
                         input logic [DATA_W-1:0] rsp, input logic [N_CH-1:0] stray_mask,
                         input bit stray_rand);
    bit                ok_ch;
    bit                success;
    int                done_rel;
    logic [N_CH-1:0]   oh;
    logic [N_CH-1:0]   exp_req;
    logic [N_CH-1:0]   ack;
    logic [DATA_W-1:0] exp_fsm;
    logic [DATA_W-1:0] exp_data;
    logic [3:0]        exp_ctl;
    logic [3:0]        got_ctl;
    ok_ch    = (ch < N_CH);
    success  = ok_ch && is_wait_cycle(d);
    done_rel = !ok_ch ? 1 : (success ? d + 1 : LAST + 1);
    oh = '0;
    if (ok_ch) oh[ch] = 1'b1;
    exp_data = success ? rsp : '0;

    bus.jtag_in    = word;
    bus.jtag_ch    = CH_W'(ch);
    bus.jtag_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.jtag_valid = 1'b0;
    bus.jtag_in    = rand_word();
    bus.jtag_ch    = CH_W'($urandom_range(0, 3));

    for (int r = 1; r <= done_rel + 1; r++) begin
      exp_req = (r < done_rel && is_wait_cycle(r)) ? oh : '0;
      exp_fsm = (exp_req != '0) ? word : '0;
      exp_ctl = {r == done_rel, r == done_rel, r <= done_rel, r == done_rel + 1};
      got_ctl = {bus.rsp_valid, bus.irq, busy, bus.jtag_ready};
      vectors++;
      if (bus.ami_req !== exp_req) begin
        miscompares++;
        $display("FAIL ami_req ch=%0d d=%0d r=%0d got=%b exp=%b", ch, d, r, bus.ami_req, exp_req);
      end
      vectors++;
      if (bus.fsm_ami !== exp_fsm) begin
        miscompares++;
        $display("FAIL fsm_ami ch=%0d d=%0d r=%0d got=%h exp=%h", ch, d, r, bus.fsm_ami, exp_fsm);
      end
      vectors++;
      if (got_ctl !== exp_ctl) begin
        miscompares++;
        $display("FAIL ctl(valid,irq,busy,ready) ch=%0d d=%0d r=%0d got=%b exp=%b",
                 ch, d, r, got_ctl, exp_ctl);
      end
      if (r == done_rel) begin
        if (success) m_ok  = (m_ok  < CNT_MAX) ? m_ok + 1  : CNT_MAX;
        else         m_err = (m_err < CNT_MAX) ? m_err + 1 : CNT_MAX;
      end
      if (r >= done_rel) begin
        vectors++;
        if (bus.rsp_err !== !success || bus.rsp_ch !== CH_W'(ch)) begin
          miscompares++;
          $display("FAIL rsp_err/ch d=%0d r=%0d got=%b/%0d exp=%b/%0d",
                   d, r, bus.rsp_err, bus.rsp_ch, !success, ch);
        end
        vectors++;
        if (bus.rsp_data !== exp_data) begin
          miscompares++;
          $display("FAIL rsp_data d=%0d r=%0d got=%h exp=%h", d, r, bus.rsp_data, exp_data);
        end
      end
      if (r == done_rel + 1) begin
        vectors++;
        if (ok_count !== CNT_W'(m_ok) || err_count !== CNT_W'(m_err)) begin
          miscompares++;
          $display("FAIL counters got ok=%0d err=%0d exp ok=%0d err=%0d",
                   ok_count, err_count, m_ok, m_err);
        end
      end
      if (r <= done_rel) begin
        ack = stray_mask & ~oh & (stray_rand ? N_CH'($urandom()) : {N_CH{1'b1}});
        if (r == d) ack = ack | oh;
        bus.ami_ack = ack;
        bus.ami_out = (r == d) ? rsp : rand_word();
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.ami_ack = '0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.jtag_valid = 1'b1;
    bus.jtag_in    = rand_word();
    bus.jtag_ch    = 2'd1;
    bus.ami_ack    = '0;
    bus.ami_out    = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({bus.ami_req, bus.rsp_valid, bus.rsp_err, bus.irq, busy, bus.jtag_ready} !== '0 ||
          bus.fsm_ami !== '0 || bus.rsp_data !== '0 || bus.rsp_ch !== '0 ||
          ok_count !== '0 || err_count !== '0) begin
        miscompares++;
        $display("FAIL reset_state req=%b valid=%b busy=%b ready=%b ok=%0d err=%0d exp all zero",
                 bus.ami_req, bus.rsp_valid, busy, bus.jtag_ready, ok_count, err_count);
      end
    end
    bus.jtag_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.jtag_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset got=%b exp=1", bus.jtag_ready);
    end
    m_ok  = 0;
    m_err = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] w;
    w = {32{8'hA5}};
    run_cmd(w, 1, 5, 256'h1234, '0, 1'b0);
  endtask

  task automatic test_timeout();
    run_cmd(rand_word(), 0, 0, rand_word(), '0, 1'b0);
    run_cmd(rand_word(), 2, TIMEOUT + 1, rand_word(), '0, 1'b0);
    run_cmd(rand_word(), 1, LAST, rand_word(), '0, 1'b0);
    run_cmd(rand_word(), 1, LAST + 1, rand_word(), '0, 1'b0);
  endtask

  task automatic test_bad_channel();
    run_cmd(rand_word(), 3, 1, rand_word(), 3'b111, 1'b1);
  endtask

  task automatic test_collision();
    run_cmd(rand_word(), 2, TIMEOUT, rand_word(), 3'b001, 1'b0);
    run_cmd(rand_word(), 0, 2 * TIMEOUT + 1, rand_word(), 3'b110, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    bus.jtag_in    = rand_word();
    bus.jtag_ch    = 2'd0;
    bus.jtag_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.jtag_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.ami_req !== 3'b001) begin
      miscompares++;
      $display("FAIL req_before_reset got=%b exp=001", bus.ami_req);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_ok  = 0;
    m_err = 0;
    vectors++;
    if (bus.ami_req !== '0 || ok_count !== '0 || err_count !== '0 ||
        bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_wait req=%b ok=%0d err=%0d valid=%b busy=%b exp 0",
               bus.ami_req, ok_count, err_count, bus.rsp_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.jtag_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release got=%b exp=1", bus.jtag_ready);
    end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.ami_req !== '0) begin
        miscompares++;
        $display("FAIL quiet_after_reset valid=%b busy=%b req=%b exp 0/0/000",
                 bus.rsp_valid, busy, bus.ami_req);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++)
      run_cmd(rand_word(), $urandom_range(0, 2), $urandom_range(1, TIMEOUT), rand_word(), '0, 1'b0);
    vectors++;
    if (ok_count !== 2'd3) begin
      miscompares++;
      $display("FAIL ok_saturation got=%0d exp=3", ok_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      run_cmd(rand_word(), $urandom_range(0, 3), $urandom_range(0, LAST + 2), rand_word(),
              N_CH'($urandom()), 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_bad_channel();
    test_collision();
    test_reset_in_wait();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ami_cmd_sequencer.md
# ami_cmd_sequencer

Parametrised successor to the single-channel FSM driver path. It accepts command words from the JTAG-side debug port and routes each one to one of `N_CH` asset-management (AMI) channels using a request/acknowledge handshake. It captures the AMI response, and retries or reports an error when a per-command timeout expires. It sits between the JTAG/OEM input and the AMI endpoints, and exposes completion status to GPIO/IRQ logic.

## Interface
Parameters:
- `DATA_W`, 256, width of command and response words
- `N_CH`, 3, number of AMI channels; one request/ack bit each
- `CH_W`, `$clog2(N_CH)` (minimum 1), channel-select width
- `TIMEOUT`, 64, cycles to wait for an ack per attempt; must be ≥ 2
- `MAX_RETRY`, 2, re-issues after a timeout before an error is declared
- `CNT_W`, 8, width of the saturating status counters

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `jtag_in`  in  `DATA_W`  command word
- `jtag_ch`  in  `CH_W`  target channel for `jtag_in`
- `jtag_valid`  in  1  command offered
- `jtag_ready`  out  1  sequencer can accept a command
- `fsm_ami`  out  `DATA_W`  command word driven to AMI; 0 when no request is active
- `ami_req`  out  `N_CH`  one-hot request, held until ack, timeout or abort
- `ami_ack`  in  `N_CH`  per-channel acknowledge
- `ami_out`  in  `DATA_W`  AMI response, valid while the matching ack is high
- `rsp_data`  out  `DATA_W`  captured response; 0 on error
- `rsp_ch`  out  `CH_W`  channel of the reported result
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_err`  out  1  qualifies `rsp_valid`: timeout or bad channel
- `busy`  out  1  high in any state other than IDLE
- `irq`  out  1  one-cycle pulse, coincident with `rsp_valid`
- `ok_count`  out  `CNT_W`  saturating count of successful commands
- `err_count`  out  `CNT_W`  saturating count of errored commands

## Operation
- States:
  - IDLE: `jtag_ready`=1.
  - WAIT: `ami_req[ch]`=1 and `fsm_ami`=the latched word; the timer runs.
  - GAP: one cycle with the request dropped.
  - DONE: success is reported.
  - ERR: the error is reported.
- IDLE, on `jtag_valid & jtag_ready`:
  - Latch the word and channel, and clear the timer and retry count.
  - Go to WAIT if `jtag_ch` < `N_CH`.
  - Otherwise go to ERR with no request issued.
- WAIT, on `ami_ack[ch]`=1:
  - Capture `ami_out` into `rsp_data` and go to DONE.
  - Acks on non-selected channels are ignored.
- WAIT, timer reaching `TIMEOUT-1` without an ack:
  - Go to GAP if retries < `MAX_RETRY`, incrementing the retry count.
  - Otherwise go to ERR.
- GAP goes to WAIT with the timer cleared.
- Ack in the same cycle as timer expiry: the ack wins and the FSM goes to DONE.
- DONE: `rsp_valid`=1, `rsp_err`=0, `irq`=1, `ok_count`+1 (saturating at all-ones); then IDLE.
- ERR: `rsp_valid`=1, `rsp_err`=1, `irq`=1, `rsp_data`=0, `err_count`+1 (saturating); then IDLE.
- `rsp_data`, `rsp_ch` and `rsp_err` hold their value until the next result.
- Reset mid-operation: the request drops on the next edge. No result is reported and the counters are cleared.

## Timing
- All outputs reset to 0, including `rsp_*`, the counters, `ami_req`, `fsm_ami`, `busy` and `irq`.
- `jtag_ready` is 1 from the first cycle after `rst_n` rises. `jtag_valid` is ignored while `rst_n`=0.
- Command accepted at edge N:
  - `ami_req` and `busy` are high from cycle N+1.
- Ack sampled at edge M:
  - `rsp_valid` is high in cycle M+1.
  - `jtag_ready` is high in cycle M+2.
- Minimum command turnaround, with ack in the first WAIT cycle, is 3 cycles.
- Timeout, no retries: `ami_req` is high for exactly `TIMEOUT` cycles per attempt, with one GAP cycle between attempts.
- Worst case: `(MAX_RETRY+1)*TIMEOUT + MAX_RETRY` WAIT/GAP cycles, then the ERR cycle.
- `jtag_ready` is combinational from state. `fsm_ami`, `ami_req`, `rsp_*` and `irq` are registered.

## Structure
- Package `ami_seq_pkg`:
  - state enum `seq_state_t` (IDLE, WAIT, GAP, DONE, ERR)
  - helper `ch_onehot()`
  - local constants for timer and retry widths
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst_n`, `inc`, `count`): instantiated twice, for `ok_count` and `err_count`.

## Test plan
- Basic success: `jtag_in`=`256'hA5..A5`, `jtag_ch`=1, ack on channel 1 after 5 cycles with `ami_out`=`256'h1234` -> `ami_req`=`3'b010`; one `rsp_valid` with `rsp_data`=`256'h1234`, `rsp_ch`=1, `rsp_err`=0; `ok_count`=1.
- Timeout with retries: `TIMEOUT`=8, `MAX_RETRY`=2, no ack -> three 8-cycle request pulses separated by 1-cycle gaps; `rsp_err`=1, `rsp_data`=0, `err_count`=1.
- Bad channel: `jtag_ch`=3 with `N_CH`=3 -> no `ami_req` activity; ERR on the cycle after acceptance; `irq` pulses once.
- Collision and stray ack: ack on channel 0 while targeting channel 2 is ignored. Channel 2 ack in the timeout cycle -> success, not retry.
- Reset in WAIT: `rst_n` low for 1 cycle -> `ami_req`=0 and counters=0 next cycle; no `rsp_valid`; `jtag_ready`=1 after release.
- Saturation: with `CNT_W`=2, 5 successes -> `ok_count`=3.
